traffic_phase_fsm: RTL and testbench
====================================

Name: traffic_phase_fsm

Overview:
- Phase controller that drives the `state` code consumed by the countdown timer and advances on that timer's `expired` pulse.
- Serves four approach roads round-robin. Each served road gets primary or extended green depending on its congestion flag, followed by yellow, followed by all-red.
- Skips roads with no waiting vehicles and forces an orderly yellow on an emergency request.
- Sits between the road sensors, the timer and the lamp drivers.

Parameters:
- SKIP_EMPTY, 1: 1 = a road with `vehicle_present` low is not granted green; 0 = every road is served in turn.
- START_ROAD, 0: road index loaded into the round-robin pointer at reset (0..3).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- expired  input  1  one-cycle pulse from the timer: the current phase duration has elapsed.
- vehicle_present  input  4  bit r high = vehicles waiting on road r; level, sampled each cycle.
- congestion  input  4  bit r high = road r congested; selects extended green.
- emergency  input  1  level; while high, no new green is granted and an active green is cut to yellow.
- state  output  4  phase code driven to the timer (encoding below).
- lights  output  8  2 bits per road, road r at [2r+1:2r]; 00 = red, 01 = yellow, 10 = green, 11 never driven.
- active_road  output  2  road currently holding green or yellow; holds the last served road while in ALL_RED.
- grant  output  1  one-cycle pulse on every entry into a green state.

Behaviour:
- Encoding: ALL_RED = 0. For road r, PG = 1+3r, EG = 2+3r, Y = 3+3r. Legal codes are 0..12.
- Reset values: state = 0, lights = 8'h00, active_road = START_ROAD, grant = 0, round-robin pointer = START_ROAD, settle flag = 1.
- Settle guard:
  - The settle flag sets on every state change and clears on the following cycle.
  - `expired` is ignored while settle = 1, covering the cycle before the timer sees the new code.
- `state` is registered, so a transition is visible one cycle after the qualifying `expired`.
- ALL_RED with qualified `expired` and emergency low:
  - Search roads pointer, pointer+1, … mod 4 for the first road with `vehicle_present` set. With SKIP_EMPTY = 0 the pointer road is chosen directly.
  - If the chosen road r has `congestion[r]` set in that cycle, go to EG(r); otherwise go to PG(r).
  - Pulse `grant` and set `active_road` = r.
  - If no road has demand, stay in ALL_RED; the timer self-reloads and the search retries on the next `expired`.
- PG(r) or EG(r) with qualified `expired` -> Y(r).
- Congestion changes during green do not switch between PG and EG.
- Y(r) with qualified `expired` -> ALL_RED, pointer = (r+1) mod 4. Wrap-around: road 3 -> pointer 0.
- Emergency:
  - In PG/EG, emergency high -> Y(r) on the next cycle, regardless of `expired` or settle.
  - Y completes normally.
  - ALL_RED holds while emergency is high, even on `expired`.
  - The pointer still advances past the pre-empted road.
- Simultaneous `expired` and emergency in green: single transition to Y(r).
- Illegal state 13..15: go to ALL_RED next cycle, keep the pointer, assert no grant.
- `lights` and `active_road` are registered alongside `state` and decoded from the next state, so they change on the same edge as `state`.
- Lamp decode: ALL_RED = all 00. PG/EG of r = road r 10, others 00. Y of r = road r 01, others 00.
- Invariant: at most one road is non-red at any time.
- Reset mid-phase: immediate return to reset values; green never persists through reset.

Decomposition:
- Shared package traffic_pkg:
  - state code constants ST_ALL_RED, ST_PG0..ST_Y3;
  - light codes LT_RED/LT_YEL/LT_GRN;
  - NUM_ROADS = 4.
- The timer uses the same constants.
- One natural sub-module: rr_road_select.
  - Purely combinational.
  - Inputs: pointer, demand mask, SKIP_EMPTY.
  - Outputs: found flag and road index.

Test Plan:
- Reset, then `vehicle_present` = 4'b1111, `congestion` = 0, `expired` pulsed 2 cycles after each state change -> states 0,1,3,0,4,6,0,7,9,0,10,12,0,1; `grant` pulses 4 times; `lights` shows 8'h02 in state 1 and 8'h01 in state 3.
- `vehicle_present` = 4'b0100, pointer 0, `expired` in ALL_RED -> next state 7 (PG2), `active_road` = 2; after Y2 the pointer is 3, and the next grant is again road 2 (search wraps 3 -> 0 -> 1 -> 2).
- `congestion` = 4'b0010 with all demand -> road 1 enters state 5 (EG1); road 0 enters state 1. Integrated with the timer at defaults: road 1 green dwell exceeds road 0 green dwell by 10 cycles.
- Emergency raised 3 cycles into PG0 -> state 3 on the next cycle; then 0 after `expired`; stays 0 through 3 `expired` pulses while emergency is high; after release, the next grant goes to road 1.
- `expired` held high continuously -> exactly one transition per two cycles (settle guard); no state is skipped.
- `vehicle_present` = 0 with SKIP_EMPTY = 1 -> state stays 0, `grant` never pulses. Assert `rst` mid-EG3 -> `state` = 0 and `lights` = 8'h00 asynchronously.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase codes, lamp codes and decode helpers for the traffic controller
package traffic_pkg;

  localparam int NUM_ROADS = 4;

  localparam logic [1:0] LT_RED = 2'b00;
  localparam logic [1:0] LT_YEL = 2'b01;
  localparam logic [1:0] LT_GRN = 2'b10;

  typedef enum logic [3:0] {
    ST_ALL_RED = 4'd0,
    ST_PG0 = 4'd1,  ST_EG0 = 4'd2,  ST_Y0 = 4'd3,
    ST_PG1 = 4'd4,  ST_EG1 = 4'd5,  ST_Y1 = 4'd6,
    ST_PG2 = 4'd7,  ST_EG2 = 4'd8,  ST_Y2 = 4'd9,
    ST_PG3 = 4'd10, ST_EG3 = 4'd11, ST_Y3 = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    PH_ALL_RED,
    PH_GREEN,
    PH_YELLOW,
    PH_ILLEGAL
  } phase_t;

  function automatic phase_t phase_of(input state_t s);
    phase_t ph;
    case (s)
      ST_ALL_RED: ph = PH_ALL_RED;
      ST_PG0, ST_EG0, ST_PG1, ST_EG1,
      ST_PG2, ST_EG2, ST_PG3, ST_EG3: ph = PH_GREEN;
      ST_Y0, ST_Y1, ST_Y2, ST_Y3: ph = PH_YELLOW;
      default: ph = PH_ILLEGAL;
    endcase
    return ph;
  endfunction

  function automatic logic [1:0] road_of(input state_t s);
    logic [1:0] r;
    case (s)
      ST_PG1, ST_EG1, ST_Y1: r = 2'd1;
      ST_PG2, ST_EG2, ST_Y2: r = 2'd2;
      ST_PG3, ST_EG3, ST_Y3: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic state_t pg_code(input logic [1:0] r);
    return state_t'(4'd1 + 4'd3 * {2'b00, r});
  endfunction

  function automatic state_t eg_code(input logic [1:0] r);
    return state_t'(4'd2 + 4'd3 * {2'b00, r});
  endfunction

  function automatic state_t y_code(input logic [1:0] r);
    return state_t'(4'd3 + 4'd3 * {2'b00, r});
  endfunction

  function automatic logic [7:0] lamp_word(input phase_t ph, input logic [1:0] r);
    logic [7:0] w;
    w = '0;
    case (ph)
      PH_GREEN:  w[{r, 1'b0} +: 2] = LT_GRN;
      PH_YELLOW: w[{r, 1'b0} +: 2] = LT_YEL;
      default:   w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/traffic_phase_fsm_if.sv
// rtl/traffic_phase_fsm_if.sv - sensor/timer/lamp bundle seen by the phase controller
interface traffic_phase_fsm_if;
  logic       expired;
  logic [3:0] vehicle_present;
  logic [3:0] congestion;
  logic       emergency;
  logic [3:0] state;
  logic [7:0] lights;
  logic [1:0] active_road;
  logic       grant;

  modport master (
    input  expired, vehicle_present, congestion, emergency,
    output state, lights, active_road, grant
  );

  modport slave (
    output expired, vehicle_present, congestion, emergency,
    input  state, lights, active_road, grant
  );
endinterface

// File: rtl/rr_road_select.sv
// rtl/rr_road_select.sv - round-robin search for the first road with demand, starting at ptr
module rr_road_select
  import traffic_pkg::*;
#(
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic [1:0] ptr,
  input  logic [3:0] demand,
  output logic       found,
  output logic [1:0] road
);

  // Scan from the farthest offset down so the nearest road to ptr wins.
  always_comb begin
    found = 1'b0;
    road  = ptr;
    if (!SKIP_EMPTY) begin
      found = 1'b1;
    end else begin
      for (int k = NUM_ROADS - 1; k >= 0; k--) begin
        if (demand[ptr + 2'(k)]) begin
          found = 1'b1;
          road  = ptr + 2'(k);
        end
      end
    end
  end

endmodule

// File: rtl/traffic_phase_fsm.sv
// rtl/traffic_phase_fsm.sv - four-road round-robin phase controller driven by the timer's expired pulse
module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter bit         SKIP_EMPTY = 1'b1,
  parameter logic [1:0] START_ROAD = 2'd0
) (
  input logic               clk,
  input logic               rst,
  traffic_phase_fsm_if.master bus
);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] active_q, active_d;
  logic [7:0] lights_q, lights_d;
  logic       grant_q, grant_d;
  logic       settle_q;
  logic       qual_exp;
  logic       sel_found;
  logic [1:0] sel_road;

  rr_road_select #(.SKIP_EMPTY(SKIP_EMPTY)) u_select (
    .ptr    (ptr_q),
    .demand (bus.vehicle_present),
    .found  (sel_found),
    .road   (sel_road)
  );

  // The timer only sees a new code one cycle late, so its expiry is ignored right after a change.
  assign qual_exp = bus.expired & ~settle_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = 1'b0;
    active_d = active_q;
    lights_d = '0;
    case (phase_of(state_q))
      PH_ALL_RED: begin
        if (qual_exp && !bus.emergency && sel_found) begin
          state_d = bus.congestion[sel_road] ? eg_code(sel_road) : pg_code(sel_road);
          grant_d = 1'b1;
        end
      end
      PH_GREEN: begin
        if (bus.emergency || qual_exp)
          state_d = y_code(road_of(state_q));
      end
      PH_YELLOW: begin
        if (qual_exp) begin
          state_d = ST_ALL_RED;
          ptr_d   = road_of(state_q) + 2'd1;
        end
      end
      default: state_d = ST_ALL_RED;
    endcase
    // Lamps and active road follow the next state so they switch on the same edge.
    if (phase_of(state_d) == PH_GREEN || phase_of(state_d) == PH_YELLOW) begin
      active_d = road_of(state_d);
      lights_d = lamp_word(phase_of(state_d), road_of(state_d));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ALL_RED;
      ptr_q    <= START_ROAD;
      active_q <= START_ROAD;
      lights_q <= '0;
      grant_q  <= 1'b0;
      settle_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
      lights_q <= lights_d;
      grant_q  <= grant_d;
      settle_q <= (state_d != state_q);
    end
  end

  assign bus.state       = state_q;
  assign bus.lights      = lights_q;
  assign bus.active_road = active_q;
  assign bus.grant       = grant_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// tb/tb_traffic_phase_fsm.sv - directed and randomized checks of traffic_phase_fsm against a behavioural model
module tb_traffic_phase_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  traffic_phase_fsm_if bus();

  traffic_phase_fsm #(.SKIP_EMPTY(1'b1), .START_ROAD(2'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase code n>0 means road (n-1)/3, kind (n-1)%3 (0 PG, 1 EG, 2 Y).
  int         m_state, m_ptr, m_active;
  bit         m_settle, m_grant;
  logic [7:0] m_lights;

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_active = 0; m_settle = 1; m_grant = 0; m_lights = 8'h00;
  endtask

  task automatic model_tick();
    int nxt, nptr, road, kind, r;
    bit qual, got;
    qual = bus.expired && !m_settle;
    nxt = m_state; nptr = m_ptr; got = 0;
    if (m_state == 0) begin
      if (qual && !bus.emergency)
        for (int k = 0; k < 4; k++) begin
          r = (m_ptr + k) % 4;
          if (!got && bus.vehicle_present[r]) begin
            got = 1;
            nxt = 1 + 3 * r + (bus.congestion[r] ? 1 : 0);
          end
        end
    end else begin
      road = (m_state - 1) / 3;
      kind = (m_state - 1) % 3;
      if (kind < 2 && (qual || bus.emergency)) nxt = 3 + 3 * road;
      else if (kind == 2 && qual) begin nxt = 0; nptr = (road + 1) % 4; end
    end
    m_settle = (nxt != m_state);
    m_grant = got;
    m_state = nxt;
    m_ptr = nptr;
    if (nxt != 0) begin
      m_active = (nxt - 1) / 3;
      m_lights = 8'((((nxt - 1) % 3 == 2) ? 1 : 2) << (2 * m_active));
    end else begin
      m_lights = 8'h00;
    end
  endtask

  task automatic cycle();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pair();
    bus.expired = 1'b0;
    cycle();
    bus.expired = 1'b1;
    cycle();
    bus.expired = 1'b0;
  endtask

  task automatic do_reset();
    bus.expired = 0; bus.emergency = 0; bus.vehicle_present = 0; bus.congestion = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.expired = 0; bus.emergency = 0; bus.vehicle_present = 4'hF; bus.congestion = 0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.lights !== 8'h00 || bus.active_road !== 2'd0 || bus.grant !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d lights=%h active=%0d grant=%b, required 0/00/0/0",
               bus.state, bus.lights, bus.active_road, bus.grant);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    int seq[13] = '{1, 3, 0, 4, 6, 0, 7, 9, 0, 10, 12, 0, 1};
    int grants = 0;
    do_reset();
    bus.vehicle_present = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      bus.expired = 1'b0;
      cycle();
      if (i < 12 && bus.grant === 1'b1) grants++;
      bus.expired = 1'b1;
      cycle();
      bus.expired = 1'b0;
      if (i < 12 && bus.grant === 1'b1) grants++;
      checks++;
      if (bus.state !== 4'(seq[i])) begin
        errors++;
        $display("FAIL rr_seq[%0d]: state=%0d required %0d", i, bus.state, seq[i]);
      end
      if (i == 0) begin
        checks++;
        if (bus.lights !== 8'h02) begin errors++; $display("FAIL rr_lights_pg0: %h required 02", bus.lights); end
      end
      if (i == 1) begin
        checks++;
        if (bus.lights !== 8'h01) begin errors++; $display("FAIL rr_lights_y0: %h required 01", bus.lights); end
      end
      if (i == 3) begin
        checks++;
        if (bus.active_road !== 2'd1) begin errors++; $display("FAIL rr_active: %0d required 1", bus.active_road); end
      end
    end
    checks++;
    if (grants != 4) begin errors++; $display("FAIL rr_grants: %0d required 4", grants); end
  endtask

  task automatic test_skip_wrap();
    int seq[4] = '{7, 9, 0, 7};
    do_reset();
    bus.vehicle_present = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      pulse_pair();
      checks++;
      if (bus.state !== 4'(seq[i]) || (i == 0 && (bus.active_road !== 2'd2 || bus.lights !== 8'h20))) begin
        errors++;
        $display("FAIL skip_wrap[%0d]: state=%0d active=%0d lights=%h required state %0d", i,
                 bus.state, bus.active_road, bus.lights, seq[i]);
      end
    end
  endtask

  task automatic test_congestion();
    int seq[6] = '{1, 3, 0, 5, 6, 0};
    do_reset();
    bus.vehicle_present = 4'b1111;
    bus.congestion = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      pulse_pair();
      checks++;
      if (bus.state !== 4'(seq[i])) begin
        errors++;
        $display("FAIL congestion[%0d]: state=%0d required %0d", i, bus.state, seq[i]);
      end
    end
  endtask

  task automatic test_emergency();
    do_reset();
    bus.vehicle_present = 4'b1111;
    pulse_pair();
    for (int i = 0; i < 3; i++) cycle();
    bus.emergency = 1'b1;
    cycle();
    checks++;
    if (bus.state !== 4'd3) begin errors++; $display("FAIL emerg_cut: state=%0d required 3", bus.state); end
    pulse_pair();
    checks++;
    if (bus.state !== 4'd0) begin errors++; $display("FAIL emerg_allred: state=%0d required 0", bus.state); end
    for (int i = 0; i < 3; i++) begin
      pulse_pair();
      checks++;
      if (bus.state !== 4'd0 || bus.grant !== 1'b0) begin
        errors++;
        $display("FAIL emerg_hold[%0d]: state=%0d grant=%b required 0/0", i, bus.state, bus.grant);
      end
    end
    bus.emergency = 1'b0;
    pulse_pair();
    checks++;
    if (bus.state !== 4'd4 || bus.active_road !== 2'd1) begin
      errors++;
      $display("FAIL emerg_release: state=%0d active=%0d required 4/1", bus.state, bus.active_road);
    end
  endtask

  task automatic test_expired_held();
    int seq[12] = '{1, 3, 0, 4, 6, 0, 7, 9, 0, 10, 12, 0};
    int prev, idx;
    do_reset();
    bus.vehicle_present = 4'b1111;
    bus.expired = 1'b1;
    prev = 0; idx = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      checks++;
      if ((int'(bus.state) != prev) != (i % 2 == 1)) begin
        errors++;
        $display("FAIL held_rate[%0d]: state=%0d prev=%0d", i, bus.state, prev);
      end
      if (int'(bus.state) != prev && idx < 12) begin
        checks++;
        if (bus.state !== 4'(seq[idx])) begin
          errors++;
          $display("FAIL held_seq[%0d]: state=%0d required %0d", idx, bus.state, seq[idx]);
        end
        idx++;
      end
      prev = int'(bus.state);
    end
    bus.expired = 1'b0;
  endtask

  task automatic test_no_demand();
    do_reset();
    bus.vehicle_present = 4'b0000;
    bus.expired = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (bus.state !== 4'd0 || bus.grant !== 1'b0 || bus.lights !== 8'h00) begin
        errors++;
        $display("FAIL no_demand[%0d]: state=%0d grant=%b lights=%h required 0/0/00", i,
                 bus.state, bus.grant, bus.lights);
      end
    end
    bus.expired = 1'b0;
  endtask

  task automatic test_random();
    int nonred;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.expired = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) bus.emergency = ~bus.emergency;
      if ($urandom_range(0, 7) == 0) bus.vehicle_present = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.congestion = 4'($urandom);
      cycle();
      checks++;
      if (bus.state !== 4'(m_state) || bus.lights !== m_lights ||
          bus.active_road !== 2'(m_active) || bus.grant !== m_grant) begin
        errors++;
        $display("FAIL random[%0d]: state=%0d lights=%h active=%0d grant=%b required %0d/%h/%0d/%b",
                 i, bus.state, bus.lights, bus.active_road, bus.grant,
                 m_state, m_lights, m_active, m_grant);
      end
      nonred = 0;
      for (int r = 0; r < 4; r++) if (bus.lights[2*r +: 2] != 2'b00) nonred++;
      checks++;
      if (nonred > 1) begin errors++; $display("FAIL one_road[%0d]: %0d non-red roads", i, nonred); end
    end
    bus.expired = 1'b0; bus.emergency = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.vehicle_present = 4'b1000;
    bus.congestion = 4'b1000;
    pulse_pair();
    checks++;
    if (bus.state !== 4'd11 || bus.lights !== 8'h80) begin
      errors++;
      $display("FAIL eg3_entry: state=%0d lights=%h required 11/80", bus.state, bus.lights);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.lights !== 8'h00 || bus.active_road !== 2'd0 || bus.grant !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: state=%0d lights=%h active=%0d grant=%b required 0/00/0/0",
               bus.state, bus.lights, bus.active_road, bus.grant);
    end
    do_reset();
  endtask

  initial begin
    bus.expired = 0; bus.emergency = 0; bus.vehicle_present = 0; bus.congestion = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_congestion();
    test_emergency();
    test_expired_held();
    test_no_demand();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
